mul_share_arbiter: RTL and testbench



---
 rtl/mul_share_arbiter_if.sv | 37 +++
 rtl/mul_share_arbiter.sv | 124 ++++++++++++
 tb/tb_mul_share_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_arbiter_if.sv
// Bundle between the requesters/multiplier side and the multiplier-sharing arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface mul_share_arbiter_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IDW   = 2
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_ready;
   logic [WIDTH-1:0]      mul_a;
   logic [WIDTH-1:0]      mul_b;
   logic                  mul_do;
   logic [2*WIDTH-1:0]    mul_result;
   logic                  mul_done;
   logic                  rsp_valid;
   logic [IDW-1:0]        rsp_id;
   logic [2*WIDTH-1:0]    rsp_data;
   logic [CW-1:0]         outstanding;
   logic                  err_unexpected;

   modport slave (
      input  req_valid, req_a, req_b, mul_result, mul_done,
      output req_ready, mul_a, mul_b, mul_do, rsp_valid, rsp_id, rsp_data,
             outstanding, err_unexpected
   );

   modport master (
      output req_valid, req_a, req_b, mul_result, mul_done,
      input  req_ready, mul_a, mul_b, mul_do, rsp_valid, rsp_id, rsp_data,
             outstanding, err_unexpected
   );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NREQ requesters.
// Issued requester IDs ride an in-order tag FIFO so each product returns to its originator.
module mul_share_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IDW   = 2
) (
   input logic               clk,
   input logic               reset,
   mul_share_arbiter_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = IDW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [IDW-1:0]     r_rr_ptr;
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [CW-1:0]      r_count;
   logic [IDW-1:0]     r_tag [DEPTH];
   logic [WIDTH-1:0]   r_mul_a;
   logic [WIDTH-1:0]   r_mul_b;
   logic               r_mul_do;
   logic               r_rsp_valid;
   logic [IDW-1:0]     r_rsp_id;
   logic [2*WIDTH-1:0] r_rsp_data;
   logic               r_err;

   logic [WIDTH-1:0]   w_a [NREQ];
   logic [WIDTH-1:0]   w_b [NREQ];
   logic               w_can_issue;
   logic               w_hs;
   logic               w_pop;
   logic [NREQ-1:0]    w_grant;
   logic [IDW-1:0]     w_gid;
   logic [IDW-1:0]     w_idx;
   logic [SW-1:0]      w_sum;
   logic [WIDTH-1:0]   w_sel_a;
   logic [WIDTH-1:0]   w_sel_b;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign w_a[i] = bus.req_a[i*WIDTH +: WIDTH];
      assign w_b[i] = bus.req_b[i*WIDTH +: WIDTH];
   end

   // First valid requester at or after rr_ptr wins; no grant while the tag FIFO is full
   always_comb begin
      w_grant     = '0;
      w_gid       = '0;
      w_idx       = '0;
      w_sum       = '0;
      w_sel_a     = '0;
      w_sel_b     = '0;
      w_hs        = 1'b0;
      w_can_issue = !reset && (r_count < DEPTH_C);
      for (int unsigned k = 0; k < NREQ; k++) begin
         w_sum = SW'(r_rr_ptr) + SW'(k);
         if (w_sum >= SW'(NREQ)) w_sum = w_sum - SW'(NREQ);
         w_idx = w_sum[IDW-1:0];
         if (w_can_issue && !w_hs && bus.req_valid[w_idx]) begin
            w_hs           = 1'b1;
            w_gid          = w_idx;
            w_grant[w_idx] = 1'b1;
            w_sel_a        = w_a[w_idx];
            w_sel_b        = w_b[w_idx];
         end
      end
   end

   assign w_pop = bus.mul_done && (r_count != '0);

   // Tag storage carries no reset; occupancy is tracked by r_count
   always_ff @(posedge clk) begin
      if (!reset && w_hs) r_tag[r_wr_ptr] <= w_gid;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_mul_a     <= '0;
         r_mul_b     <= '0;
         r_mul_do    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
         r_err       <= 1'b0;
      end else begin
         r_mul_do    <= w_hs;
         r_rsp_valid <= w_pop;
         if (w_hs) begin
            r_mul_a  <= w_sel_a;
            r_mul_b  <= w_sel_b;
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rr_ptr <= (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;
         end
         if (w_pop) begin
            r_rsp_id   <= r_tag[r_rd_ptr];
            r_rsp_data <= bus.mul_result;
            r_rd_ptr   <= r_rd_ptr + 1'b1;
         end
         if (bus.mul_done && (r_count == '0)) r_err <= 1'b1;
         case ({w_hs, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.req_ready      = w_grant;
   assign bus.mul_a          = r_mul_a;
   assign bus.mul_b          = r_mul_b;
   assign bus.mul_do         = r_mul_do;
   assign bus.rsp_valid      = r_rsp_valid;
   assign bus.rsp_id         = r_rsp_id;
   assign bus.rsp_data       = r_rsp_data;
   assign bus.outstanding    = r_count;
   assign bus.err_unexpected = r_err;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized bench for mul_share_arbiter against a queue-based reference of the sharing rules.
// A stand-in pipelined multiplier with selectable latency feeds results back.
module tb_mul_share_arbiter;
   localparam int unsigned NREQ  = 4;
   localparam int unsigned WIDTH = 4;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned IDW   = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mul_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .IDW(IDW)) bus ();

   mul_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .IDW(IDW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Stand-in multiplier: fixed latency, in order, flushed by the shared reset
   logic [4:0]  lat_sel = 5'd4;
   logic        spur    = 1'b0;
   logic [31:0] sr_v;
   logic [7:0]  sr_d [32];
   always @(posedge clk) begin
      if (reset) sr_v <= '0;
      else       sr_v <= {sr_v[30:0], bus.mul_do};
      sr_d[0] <= 8'(bus.mul_a) * 8'(bus.mul_b);
      for (int i = 1; i < 32; i++) sr_d[i] <= sr_d[i-1];
   end
   assign bus.mul_done   = sr_v[lat_sel] | spur;
   assign bus.mul_result = spur ? 8'h00 : sr_d[lat_sel];

   typedef struct { int id; int prod; } op_t;
   op_t m_q[$];
   int  m_rr, m_err;
   bit  e_do, e_rsp_v;
   int  e_a, e_b, e_id, e_data;
   int  va[NREQ], vb[NREQ];
   logic [NREQ-1:0] vv;
   int  last_g;
   int  n_chk = 0, n_pass = 0, n_ops = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic set_lat(input int n);
      lat_sel = 5'(n - 1);
   endtask

   task automatic apply();
      bus.req_valid = vv;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[i*WIDTH +: WIDTH] = WIDTH'(va[i]);
         bus.req_b[i*WIDTH +: WIDTH] = WIDTH'(vb[i]);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_rr = 0; m_err = 0; e_do = 0; e_rsp_v = 0;
   endtask

   // Called once per cycle with inputs settled: compare, then advance the reference
   task automatic model_cycle();
      int g;
      op_t e;
      chk("mul_do", 32'(bus.mul_do), 32'(e_do));
      if (e_do) begin
         chk("mul_a", 32'(bus.mul_a), e_a);
         chk("mul_b", 32'(bus.mul_b), e_b);
      end
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp_v));
      if (e_rsp_v) begin
         chk("rsp_id", 32'(bus.rsp_id), e_id);
         chk("rsp_data", 32'(bus.rsp_data), e_data);
      end
      chk("outstanding", 32'(bus.outstanding), m_q.size());
      chk("err_unexpected", 32'(bus.err_unexpected), m_err);
      g = -1;
      if (m_q.size() < DEPTH)
         for (int k = 0; k < NREQ; k++)
            if (g < 0 && vv[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      chk("req_ready", 32'(bus.req_ready), (g >= 0) ? (1 << g) : 0);
      last_g  = g;
      e_rsp_v = 0;
      if (bus.mul_done) begin
         if (m_q.size() == 0) m_err = 1;
         else begin
            e = m_q.pop_front();
            e_rsp_v = 1; e_id = e.id; e_data = e.prod;
         end
      end
      e_do = (g >= 0);
      if (g >= 0) begin
         e_a = va[g]; e_b = vb[g];
         m_q.push_back('{id: g, prod: va[g] * vb[g]});
         m_rr = (g + 1) % NREQ;
         n_ops++;
      end
   endtask

   task automatic cyc_post();
      model_cycle();
      @(posedge clk); #1;
   endtask

   task automatic cyc();
      @(negedge clk);
      cyc_post();
   endtask

   task automatic rand_ops();
      for (int i = 0; i < NREQ; i++) begin
         va[i] = $urandom_range(0, 15);
         vb[i] = $urandom_range(0, 15);
      end
   endtask

   task automatic do_reset();
      vv = '1; rand_ops(); apply();
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_mul_do", 32'(bus.mul_do), 0);
      chk("rst_mul_a", 32'(bus.mul_a), 0);
      chk("rst_mul_b", 32'(bus.mul_b), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 0);
      chk("rst_outstanding", 32'(bus.outstanding), 0);
      chk("rst_err", 32'(bus.err_unexpected), 0);
      vv = '0; apply();
      reset = 1'b0;
      model_reset();
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n;
      vv = '0; apply();
      n = 0;
      while ((m_q.size() != 0 || sr_v != 0 || e_rsp_v) && n < 64) begin
         cyc(); n++;
      end
      if (n >= 64) chk("drain_timeout", 0, 1);
      cyc(); cyc();
   endtask

   initial begin
      int peak, ngr, n;
      reset = 1'b1; vv = '0;
      for (int i = 0; i < NREQ; i++) begin va[i] = 0; vb[i] = 0; end
      apply();
      model_reset();
      do_reset();

      // Single request from requester 2, latency 5
      set_lat(5);
      va[2] = 9; vb[2] = 13; vv = 4'b0100; apply();
      @(negedge clk);
      chk("t1_ready", 32'(bus.req_ready), 32'h4);
      cyc_post();
      vv = '0; apply();
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("t1_mul_do", 32'(bus.mul_do), 1);
            chk("t1_mul_a", 32'(bus.mul_a), 9);
            chk("t1_mul_b", 32'(bus.mul_b), 13);
         end
         if (c == 6) chk("t1_rsp_early", 32'(bus.rsp_valid), 0);
         if (c == 7) begin
            chk("t1_rsp_valid", 32'(bus.rsp_valid), 1);
            chk("t1_rsp_id", 32'(bus.rsp_id), 2);
            chk("t1_rsp_data", 32'(bus.rsp_data), 117);
         end
         cyc_post();
      end
      drain();

      // All requesters valid from rr_ptr=0: strict rotation
      do_reset();
      vv = '1;
      for (int c = 0; c < 12; c++) begin
         rand_ops();
         if (c == 3) begin va[3] = 15; vb[3] = 15; end
         apply();
         @(negedge clk);
         chk("t2_grant", 32'(bus.req_ready), 1 << (c % NREQ));
         cyc_post();
      end
      drain();

      // Long latency fills the tag FIFO
      set_lat(12);
      vv = '1; peak = 0; ngr = 0;
      for (int c = 0; c < 40; c++) begin
         rand_ops(); apply();
         @(negedge clk);
         if (int'(bus.outstanding) > peak) peak = int'(bus.outstanding);
         if (c < 8 && bus.req_ready != 0) ngr++;
         if (c == 8 || c == 13) chk("t3_full_stall", 32'(bus.req_ready), 0);
         if (c == 14) chk("t3_resume", 32'(bus.req_ready != 0), 1);
         cyc_post();
      end
      chk("t3_first8", ngr, 8);
      chk("t3_peak", peak, 8);
      drain();

      // Steady push+pop at occupancy 5
      set_lat(4);
      vv = 4'b0010;
      for (int c = 0; c < 25; c++) begin
         rand_ops(); apply();
         @(negedge clk);
         if (c >= 15) chk("t4_steady", 32'(bus.outstanding), 5);
         cyc_post();
      end
      drain();

      // Random traffic with varied latency
      for (int p = 0; p < 6; p++) begin
         set_lat($urandom_range(1, 12));
         for (int c = 0; c < 40; c++) begin
            rand_ops();
            vv = NREQ'($urandom_range(0, 15) & $urandom_range(0, 15) | $urandom_range(0, 15));
            apply();
            cyc();
         end
         drain();
      end
      chk("t4_ops_100", 32'(n_ops >= 100), 1);

      // Spurious mul_done with nothing outstanding
      set_lat(5);
      spur = 1'b1;
      cyc();
      spur = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("t5_err_sticky", 32'(bus.err_unexpected), 1);
         chk("t5_no_rsp", 32'(bus.rsp_valid), 0);
         cyc_post();
      end

      // Reset with three operations in flight
      vv = '1;
      for (int c = 0; c < 3; c++) begin rand_ops(); apply(); cyc(); end
      vv = '0; apply();
      cyc();
      chk("t6_inflight", m_q.size(), 3);
      do_reset();
      for (int c = 0; c < 12; c++) cyc();
      va[1] = 4; vb[1] = 5; vv = 4'b0010; apply();
      cyc();
      vv = '0; apply();
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 20) begin cyc(); n++; end
      chk("t6_rsp_seen", 32'(bus.rsp_valid), 1);
      chk("t6_rsp_id", 32'(bus.rsp_id), 1);
      chk("t6_rsp_data", 32'(bus.rsp_data), 20);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end
endmodule
